decod_rr_arbiter: RTL

- Round-robin arbiter that shares one decoded resource select among 4 requesters.
- Arbitrates `req[3:0]` and registers a 2-bit winner index.
- Drives the one-hot grant through a 2-to-4 decoder with enable, so `gnt` is always one-hot or all-zero.
- Sits in front of any 4-way shared slot, e.g. a bus or memory bank, that is selected by a decoder.

---
 rtl/decod_rr_arbiter_pkg.sv | 14 +
 rtl/decod_rr_arbiter_decod.sv | 16 +
 rtl/decod_rr_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/decod_rr_arbiter_pkg.sv
// Shared types and constants for the decoded round-robin arbiter.
package decod_rr_arbiter_pkg;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  localparam logic [IDX_W-1:0] PTR_RST = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/decod_rr_arbiter_decod.sv
// 2-to-4 decoder with enable: exactly one output high when e = 1, none otherwise.
module decod_rr_arbiter_decod
  import decod_rr_arbiter_pkg::*;
(
  input  logic [IDX_W-1:0] a,
  input  logic             e,
  output logic [NREQ-1:0]  y
);

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_dec
      assign y[gi] = e && (a == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/decod_rr_arbiter.sv
// Round-robin arbiter over 4 requesters with hold timeout; the registered
// winner index drives a 2-to-4 decoder so gnt is one-hot or zero by construction.
module decod_rr_arbiter
  import decod_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             tmo
);

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
  localparam logic             TMO_EN     = (MAX_HOLD != 0);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tmo_q, tmo_d;

  logic [IDX_W:0]    pick_rr;
  logic [IDX_W:0]    pick_tmo;
  logic [NREQ-1:0]   others;

  // Returns {found, index}; scans lowest priority first so the highest-priority hit wins.
  function automatic logic [IDX_W:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [IDX_W-1:0] p);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] c;
    res = '0;
    for (int k = NREQ; k >= 1; k--) begin
      c = p + IDX_W'(k);
      if (r[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  always_comb begin
    others   = req & ~(NREQ'(1) << idx_q);
    pick_rr  = rr_pick(req, ptr_q);
    pick_tmo = rr_pick(others, idx_q);

    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;

    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_rr[IDX_W]) begin
            state_d = ST_GRANT;
            idx_d   = pick_rr[IDX_W-1:0];
            ptr_d   = pick_rr[IDX_W-1:0];
            cnt_d   = CNT_W'(1);
          end
        end
        ST_GRANT: begin
          if (!req[idx_q]) begin
            // Release wins over a coincident timeout.
            if (pick_rr[IDX_W]) begin
              idx_d = pick_rr[IDX_W-1:0];
              ptr_d = pick_rr[IDX_W-1:0];
              cnt_d = CNT_W'(1);
            end else begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end else if (TMO_EN && (cnt_q == HOLD_LIMIT)) begin
            cnt_d = CNT_W'(1);
            if (pick_tmo[IDX_W]) begin
              idx_d = pick_tmo[IDX_W-1:0];
              ptr_d = pick_tmo[IDX_W-1:0];
              tmo_d = 1'b1;
            end
          end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign gnt_idx = idx_q;
  assign gnt_vld = (state_q == ST_GRANT);
  assign tmo     = tmo_q;

  decod_rr_arbiter_decod u_decod (
    .a (idx_q),
    .e (gnt_vld),
    .y (gnt)
  );

endmodule
